// File: rtl/counter_day_month_pkg.sv
// rtl/counter_day_month_pkg.sv - shared calendar constants and BCD helpers
//
// Purpose : month numbers, month-length day counts and a BCD-to-binary
//           helper shared by the calendar counters and the alarm compare.
// Contents: bcd2_t (two-digit BCD value), FEB..DEC month numbers,
//           DAYS_28..DAYS_31, bcd2bin().
package counter_day_month_pkg;

    typedef struct packed {
        logic [3:0] ten;
        logic [3:0] unit;
    } bcd2_t;

    localparam logic [5:0] FEB = 6'd2;
    localparam logic [5:0] APR = 6'd4;
    localparam logic [5:0] JUN = 6'd6;
    localparam logic [5:0] SEP = 6'd9;
    localparam logic [5:0] NOV = 6'd11;
    localparam logic [5:0] DEC = 6'd12;

    localparam logic [4:0] DAYS_28 = 5'd28;
    localparam logic [4:0] DAYS_29 = 5'd29;
    localparam logic [4:0] DAYS_30 = 5'd30;
    localparam logic [4:0] DAYS_31 = 5'd31;

    // ten*10 + unit, built from shifts; 6 bits covers any two digits up to 39.
    function automatic logic [5:0] bcd2bin(input logic [3:0] ten, input logic [3:0] unit);
        bcd2bin = ({2'b00, ten} << 3) + ({2'b00, ten} << 1) + {2'b00, unit};
    endfunction

endpackage

// File: rtl/Led7thanh.sv
// rtl/Led7thanh.sv - BCD digit to 7-segment decoder
//
// Purpose : drives one common-anode digit, segments active-low.
// Ports   : num [3:0] BCD digit in; seg [6:0] = {g,f,e,d,c,b,a}, 0 = lit.
//           Codes above 9 blank the digit.
module Led7thanh (
    input  logic [3:0] num,
    output logic [6:0] seg
);

    always_comb begin
        seg = 7'b1111111;
        case (num)
            4'd0: seg = 7'b1000000;
            4'd1: seg = 7'b1111001;
            4'd2: seg = 7'b0100100;
            4'd3: seg = 7'b0110000;
            4'd4: seg = 7'b0011001;
            4'd5: seg = 7'b0010010;
            4'd6: seg = 7'b0000010;
            4'd7: seg = 7'b1111000;
            4'd8: seg = 7'b0000000;
            4'd9: seg = 7'b0010000;
            default: seg = 7'b1111111;
        endcase
    end

endmodule

// File: rtl/counter_day_month_month_length.sv
// rtl/counter_day_month_month_length.sv - number of days in the current month
//
// Purpose : purely combinational month length lookup.
// Ports   : mon_ten/mon_unit [3:0] BCD month; leap_year 1 = Feb has 29 days;
//           days [4:0] length of that month (28..31).
module counter_day_month_month_length
    import counter_day_month_pkg::*;
(
    input  logic [3:0] mon_ten,
    input  logic [3:0] mon_unit,
    input  logic       leap_year,
    output logic [4:0] days
);

    logic [5:0] mon;

    assign mon = bcd2bin(mon_ten, mon_unit);

    always_comb begin
        days = DAYS_31;
        case (mon)
            FEB:                days = leap_year ? DAYS_29 : DAYS_28;
            APR, JUN, SEP, NOV: days = DAYS_30;
            default:            days = DAYS_31;
        endcase
    end

endmodule

// File: rtl/counter_day_month.sv
// rtl/counter_day_month.sv - calendar day/month counter with year carry
//
// Purpose : advances the BCD day on each cd1 pulse, rolls months by month
//           length and emits cy1 on the Dec 31 -> Jan 01 rollover.
// Ports   : clk, reset (async, active-high); cd1 day-carry pulse in;
//           leap_year from the year counter; cy1 year-carry out (same cycle
//           as the cd1 that rolls the year); seg_d1/seg_d2 day units/tens,
//           seg_m1/seg_m2 month units/tens, Led7thanh encoding.
module counter_day_month
    import counter_day_month_pkg::*;
#(
    parameter int RESET_DAY   = 1,
    parameter int RESET_MONTH = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cd1,
    input  logic       leap_year,
    output logic       cy1,
    output logic [6:0] seg_d1,
    output logic [6:0] seg_d2,
    output logic [6:0] seg_m1,
    output logic [6:0] seg_m2
);

    localparam logic [3:0] RST_DAY_TEN  = 4'(RESET_DAY / 10);
    localparam logic [3:0] RST_DAY_UNIT = 4'(RESET_DAY % 10);
    localparam logic [3:0] RST_MON_TEN  = 4'(RESET_MONTH / 10);
    localparam logic [3:0] RST_MON_UNIT = 4'(RESET_MONTH % 10);

    bcd2_t      day;
    bcd2_t      mon;
    logic [4:0] month_len;
    logic [5:0] day_bin;
    logic [5:0] mon_bin;
    logic       day_last;
    logic       is_dec;

    counter_day_month_month_length u_month_length (
        .mon_ten   (mon.ten),
        .mon_unit  (mon.unit),
        .leap_year (leap_year),
        .days      (month_len)
    );

    assign day_bin = bcd2bin(day.ten, day.unit);
    assign mon_bin = bcd2bin(mon.ten, mon.unit);

    // >= rather than == so an out-of-range day (Feb 29 in a common year)
    // still rolls to the 1st of the next month instead of running on.
    assign day_last = day_bin >= {1'b0, month_len};
    assign is_dec   = mon_bin == DEC;

    // Year carry is combinational so the year counter steps on the same edge
    // that the date becomes 01/01. Masked by reset so a reset landing on a
    // Dec 31 cd1 never counts a year.
    assign cy1 = cd1 && !reset && is_dec && (day_bin == 6'd31);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            day.ten  <= RST_DAY_TEN;
            day.unit <= RST_DAY_UNIT;
            mon.ten  <= RST_MON_TEN;
            mon.unit <= RST_MON_UNIT;
        end else if (cd1) begin
            if (!day_last) begin
                if (day.unit == 4'd9) begin
                    day.unit <= 4'd0;
                    day.ten  <= day.ten + 4'd1;
                end else begin
                    day.unit <= day.unit + 4'd1;
                end
            end else begin
                day.ten  <= 4'd0;
                day.unit <= 4'd1;
                if (is_dec) begin
                    mon.ten  <= 4'd0;
                    mon.unit <= 4'd1;
                end else if (mon.unit == 4'd9) begin
                    mon.ten  <= 4'd1;
                    mon.unit <= 4'd0;
                end else begin
                    mon.unit <= mon.unit + 4'd1;
                end
            end
        end
    end

    Led7thanh u_seg_d1 (.num(day.unit), .seg(seg_d1));
    Led7thanh u_seg_d2 (.num(day.ten),  .seg(seg_d2));
    Led7thanh u_seg_m1 (.num(mon.unit), .seg(seg_m1));
    Led7thanh u_seg_m2 (.num(mon.ten),  .seg(seg_m2));

endmodule

// File: tb/tb_counter_day_month.sv
// tb/tb_counter_day_month.sv - scoreboard bench for counter_day_month
module tb_counter_day_month;

    logic       clk = 1'b0;
    logic       reset;
    logic       cd1;
    logic       leap_year;
    logic       cy1;
    logic [6:0] seg_d1;
    logic [6:0] seg_d2;
    logic [6:0] seg_m1;
    logic [6:0] seg_m2;

    counter_day_month #(.RESET_DAY(1), .RESET_MONTH(1)) dut (
        .clk       (clk),
        .reset     (reset),
        .cd1       (cd1),
        .leap_year (leap_year),
        .cy1       (cy1),
        .seg_d1    (seg_d1),
        .seg_d2    (seg_d2),
        .seg_m1    (seg_m1),
        .seg_m2    (seg_m2)
    );

    always #5 clk = ~clk;

    typedef struct {
        int day;
        int mon;
        bit chk_date;
        bit chk_cy;
        bit cy;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    bit   pending = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   cy_count = 0;
    int   cy_base;

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: seg_of = 7'b1000000;
            1: seg_of = 7'b1111001;
            2: seg_of = 7'b0100100;
            3: seg_of = 7'b0110000;
            4: seg_of = 7'b0011001;
            5: seg_of = 7'b0010010;
            6: seg_of = 7'b0000010;
            7: seg_of = 7'b1111000;
            8: seg_of = 7'b0000000;
            9: seg_of = 7'b0010000;
            default: seg_of = 7'b1111111;
        endcase
    endfunction

    task automatic check_val(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic check_date(input int d, input int m);
        string tag;
        tag = $sformatf("date_%0d_%0d", d, m);
        check_val({tag, "_d1"}, int'(seg_d1), int'(seg_of(d % 10)));
        check_val({tag, "_d2"}, int'(seg_d2), int'(seg_of(d / 10)));
        check_val({tag, "_m1"}, int'(seg_m1), int'(seg_of(m % 10)));
        check_val({tag, "_m2"}, int'(seg_m2), int'(seg_of(m / 10)));
    endtask

    // Monitor: cy1 is checked every cycle; the date is checked one cycle
    // after each cd1 against the head of the scoreboard.
    always @(negedge clk) begin
        if (!reset) begin
            if (cy1) cy_count++;
            if (pending) begin
                if (cur.chk_date) check_date(cur.day, cur.mon);
                pending = 1'b0;
            end
            if (cd1) begin
                if (q.size() == 0) begin
                    check_val("unexpected_cd1", 1, 0);
                end else begin
                    cur = q.pop_front();
                    if (cur.chk_cy) check_val("cy1_pulse", int'(cy1), int'(cur.cy));
                    pending = 1'b1;
                end
            end else begin
                check_val("cy1_idle", int'(cy1), 0);
            end
        end
    end

    task automatic step(input bit lp, input int d, input int m, input bit cy,
                        input bit chk_date, input bit chk_cy);
        exp_t e;
        e.day = d; e.mon = m; e.cy = cy; e.chk_date = chk_date; e.chk_cy = chk_cy;
        leap_year = lp;
        @(posedge clk);
        #1;
        q.push_back(e);
        cd1 = 1'b1;
        @(posedge clk);
        #1;
        cd1 = 1'b0;
    endtask

    task automatic run(input int n, input bit lp, input bit chk_cy);
        for (int i = 0; i < n; i++) step(lp, 0, 0, 1'b0, 1'b0, chk_cy);
    endtask

    task automatic chk(input bit lp, input int d, input int m, input bit cy);
        step(lp, d, m, cy, 1'b1, 1'b1);
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && (q.size() != 0 || pending); i++) @(negedge clk);
        if (q.size() != 0 || pending) check_val("drain_timeout", 1, 0);
        #1;
    endtask

    task automatic do_reset();
        drain();
        reset = 1'b1;
        cd1 = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        cd1 = 1'b0;
        leap_year = 1'b0;
        #2;
        check_val("reset_cy1", int'(cy1), 0);
        check_date(1, 1);
        do_reset();
        check_date(1, 1);
        repeat (5) @(posedge clk);
        #1;
        check_date(1, 1);

        // Day BCD carries, month ends through a full year.
        run(8, 1'b0, 1'b1);
        chk(1'b0, 10, 1, 1'b0);
        run(9, 1'b0, 1'b1);
        chk(1'b0, 20, 1, 1'b0);
        run(9, 1'b0, 1'b1);
        chk(1'b0, 30, 1, 1'b0);
        chk(1'b0, 31, 1, 1'b0);
        chk(1'b0, 1, 2, 1'b0);
        run(26, 1'b1, 1'b1);
        chk(1'b1, 28, 2, 1'b0);
        chk(1'b1, 29, 2, 1'b0);
        chk(1'b1, 1, 3, 1'b0);
        run(59, 1'b0, 1'b1);
        chk(1'b0, 30, 4, 1'b0);
        chk(1'b0, 1, 5, 1'b0);
        run(151, 1'b0, 1'b1);
        chk(1'b0, 30, 9, 1'b0);
        chk(1'b0, 1, 10, 1'b0);
        run(90, 1'b0, 1'b1);
        chk(1'b0, 31, 12, 1'b0);
        cy_base = cy_count;
        chk(1'b0, 1, 1, 1'b1);
        drain();
        check_val("dec31_cy_count", cy_count - cy_base, 1);

        // Feb 28 in a common year.
        do_reset();
        run(57, 1'b0, 1'b1);
        chk(1'b0, 28, 2, 1'b0);
        chk(1'b0, 1, 3, 1'b0);

        // Feb 29 reached in a leap year, then seen with leap_year = 0.
        do_reset();
        run(58, 1'b1, 1'b1);
        chk(1'b1, 29, 2, 1'b0);
        chk(1'b0, 1, 3, 1'b0);

        // Full common year.
        do_reset();
        cy_base = cy_count;
        run(365, 1'b0, 1'b0);
        drain();
        check_val("year365_cy_count", cy_count - cy_base, 1);
        check_date(1, 1);

        // Full leap year.
        do_reset();
        cy_base = cy_count;
        run(366, 1'b1, 1'b0);
        drain();
        check_val("year366_cy_count", cy_count - cy_base, 1);
        check_date(1, 1);

        // Reset landing in the middle of the Dec 31 cd1 pulse.
        do_reset();
        run(364, 1'b0, 1'b1);
        drain();
        check_date(31, 12);
        cy_base = cy_count;
        @(posedge clk);
        #1;
        cd1 = 1'b1;
        #1;
        check_val("pre_reset_cy1", int'(cy1), 1);
        #1;
        reset = 1'b1;
        #1;
        check_val("mid_reset_cy1", int'(cy1), 0);
        check_date(1, 1);
        @(posedge clk);
        #1;
        cd1 = 1'b0;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_date(1, 1);
        check_val("mid_reset_cy_count", cy_count - cy_base, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
